// File: rtl/mem_arbiter_if.sv
// Requester and memory-wrapper signals of the two-port memory arbiter.
// The arbiter connects through the master modport; the environment uses slave.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic        calibrated;
  logic        req0, req1;
  logic        we0, we1;
  logic [25:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_cmd, mem_wea;
  logic [25:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        cmd_rdy, write_rdy, read_arrived;
  logic        busy, err_spurious;

  modport master (
    input  calibrated, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           mem_dout, cmd_rdy, write_rdy, read_arrived,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_cmd, mem_wea,
           mem_addr, mem_din, busy, err_spurious
  );

  modport slave (
    output calibrated, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           mem_dout, cmd_rdy, write_rdy, read_arrived,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_cmd, mem_wea,
           mem_addr, mem_din, busy, err_spurious
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a DDR memory wrapper.
// One transaction in flight; every memory-side output comes straight from a flop.
`timescale 1ns/1ps
module mem_arbiter (
  input logic           ui_clk,
  input logic           sys_rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, WDATA, WCMD, RCMD, RWAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;     // port owning the current transaction
  logic        prio_q, prio_d;   // port that wins the next tie
  logic [25:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        err_q, err_d;
  logic        en_q, cmd_q, wea_q, ack0_q, ack1_q, busy_q;
  logic        pick;

  // Next-state, grant selection and read-data capture
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    prio_d   = prio_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // data arriving outside RWAIT is dropped but remembered
    err_d    = err_q | (bus.read_arrived && (state_q != RWAIT));
    pick     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
    unique case (state_q)
      IDLE: begin
        // calibration only gates new grants, never an in-flight transaction
        if (bus.calibrated && (bus.req0 || bus.req1)) begin
          gnt_d   = pick;
          prio_d  = ~pick;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          din_d   = pick ? bus.wdata1 : bus.wdata0;
          state_d = (pick ? bus.we1 : bus.we0) ? WDATA : RCMD;
        end
      end
      WDATA: if (bus.write_rdy) state_d = WCMD;
      WCMD:  if (bus.cmd_rdy)   state_d = DONE;
      RCMD:  if (bus.cmd_rdy)   state_d = RWAIT;
      RWAIT: begin
        if (bus.read_arrived) begin
          if (gnt_q) rdata1_d = bus.mem_dout;
          else       rdata0_d = bus.mem_dout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs decoded from the next state
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      prio_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      cmd_q    <= 1'b0;
      wea_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      en_q     <= (state_d == WCMD) || (state_d == RCMD);
      cmd_q    <= (state_d == RCMD);
      wea_q    <= (state_d == WDATA);
      ack0_q   <= (state_d == DONE) && !gnt_d;
      ack1_q   <= (state_d == DONE) &&  gnt_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.mem_en       = en_q;
  assign bus.mem_cmd      = cmd_q;
  assign bus.mem_wea      = wea_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = din_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;
  assign bus.busy         = busy_q;
  assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, scoreboard on acks, memory responder.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic ui_clk;
  logic sys_rst;
  mem_arbiter_if b();

  mem_arbiter dut (.ui_clk(ui_clk), .sys_rst(sys_rst), .bus(b.master));

  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  typedef struct {
    logic port; logic we; logic [25:0] addr; logic [31:0] wdata;
    int wd; int cd; int rl; logic [31:0] rv;
    int exp_lat; logic [31:0] exp_rd0; logic [31:0] exp_rd1;
  } vec_t;

  typedef struct {
    logic port; logic we; logic [25:0] addr; logic [31:0] wdata; logic [31:0] rdata;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0, errors = 0;
  int  wr_dly = 0, cmd_dly = 0, rd_lat = 1;
  logic [31:0] rd_val = '0;
  bit  spur = 0;
  int  en_cyc = 0, wea_cyc = 0, encmd_cyc = 0, illegal = 0;

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {b.ack0, b.ack1, b.mem_en, b.mem_cmd, b.mem_wea, b.mem_addr, b.mem_din,
            b.rdata0, b.rdata1, b.busy, b.err_spurious};
  endfunction

  // Memory wrapper model: stalls write/cmd acceptance and delays read data
  initial begin
    int wcnt, ccnt, rcnt;
    logic rw;
    wcnt = 0; ccnt = 0; rcnt = 0;
    b.write_rdy = 0; b.cmd_rdy = 0; b.read_arrived = 0; b.mem_dout = '0;
    forever begin
      @(negedge ui_clk);
      wcnt = b.mem_wea ? wcnt + 1 : 0;
      ccnt = b.mem_en  ? ccnt + 1 : 0;
      rw   = b.busy && !b.mem_en && !b.mem_wea && !b.ack0 && !b.ack1;
      rcnt = rw ? rcnt + 1 : 0;
      b.write_rdy    = (wcnt > wr_dly);
      b.cmd_rdy      = (ccnt > cmd_dly);
      b.read_arrived = (rw && rcnt >= rd_lat) || spur;
      b.mem_dout     = rd_val;
    end
  end

  // Scoreboard and protocol monitor
  initial begin
    logic        prev_busy, prev_ack, unstable;
    logic [25:0] prev_addr;
    logic [31:0] prev_din;
    sb_t e;
    prev_busy = 0; prev_ack = 0; unstable = 0; prev_addr = '0; prev_din = '0;
    forever begin
      @(negedge ui_clk);
      if (!sys_rst) begin
        prev_busy = 0; prev_ack = 0; unstable = 0;
      end else begin
        if (b.mem_en && b.mem_wea) illegal++;
        if (b.mem_en) en_cyc++;
        if (b.mem_wea) wea_cyc++;
        if (b.mem_en && b.mem_cmd) encmd_cyc++;
        if (b.busy && prev_busy && (b.mem_addr != prev_addr || b.mem_din != prev_din))
          unstable = 1;
        if (b.ack0 || b.ack1) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with nothing outstanding", b.ack0, b.ack1);
          end else begin
            e = sb_q.pop_front();
            chk("ack_port", {b.ack1, b.ack0}, e.port ? 2'b10 : 2'b01);
            chk("ack_addr", b.mem_addr, e.addr);
            chk("addr_din_stable", unstable, 1'b0);
            chk("ack_one_cycle", prev_ack, 1'b0);
            if (e.we) chk("ack_wdata", b.mem_din, e.wdata);
            else      chk("ack_rdata", e.port ? b.rdata1 : b.rdata0, e.rdata);
          end
          unstable = 0;
        end
        prev_busy = b.busy;
        prev_ack  = b.ack0 | b.ack1;
        prev_addr = b.mem_addr;
        prev_din  = b.mem_din;
      end
    end
  end

  task automatic set_mem(int wd, int cd, int rl, logic [31:0] rv);
    wr_dly = wd; cmd_dly = cd; rd_lat = rl; rd_val = rv;
  endtask

  task automatic start_req(logic port, logic we, logic [25:0] addr, logic [31:0] wdata,
                           logic [31:0] rv, bit push);
    if (push) sb_q.push_back('{port, we, addr, wdata, rv});
    if (!port) begin b.we0 = we; b.addr0 = addr; b.wdata0 = wdata; b.req0 = 1; end
    else       begin b.we1 = we; b.addr1 = addr; b.wdata1 = wdata; b.req1 = 1; end
  endtask

  task automatic wait_ack(logic port, output int lat);
    bit got;
    got = 0; lat = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ui_clk);
      lat++;
      got = port ? b.ack1 : b.ack0;
    end
    if (!got) begin
      checks++; errors++; lat = -1;
      $display("FAIL ack_timeout: port%0d got no ack within 300 cycles", port);
    end
    if (!port) b.req0 = 0; else b.req1 = 0;
  endtask

  task automatic port_loop(logic port, int n);
    int lat;
    for (int k = 0; k < n; k++) begin
      start_req(port, !port, (port ? 26'h200 : 26'h100) + 26'(k), 32'h0F000000 + k, rd_val, 1'b0);
      wait_ack(port, lat);
      @(posedge ui_clk); @(negedge ui_clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat, seen;
    vecs[0] = '{1'b0, 1'b1, 26'h0000010, 32'h11111111, 0, 0, 1, 32'h0,        3, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 26'h3FFFFFF, 32'h0,        0, 0, 1, 32'hCAFEF00D, 3, 32'h0,        32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b0, 26'h0000003, 32'h0,        0, 4, 10, 32'hDEADBEEF, 16, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 26'h2AAAAAA, 32'hA5A5A5A5, 2, 1, 1, 32'h0,        6, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 26'h0000004, 32'h44444444, 0, 3, 1, 32'h0,        6, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 26'h1555555, 32'h0,        0, 2, 3, 32'h12345678, 7, 32'hDEADBEEF, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 26'h0000000, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, 32'h12345678};
    vecs[7] = '{1'b1, 1'b1, 26'h0000007, 32'h77777777, 1, 0, 1, 32'h0,        4, 32'hFFFFFFFF, 32'h12345678};

    sys_rst = 0; b.calibrated = 0; b.req0 = 0; b.req1 = 0; b.we0 = 0; b.we1 = 0;
    b.addr0 = '0; b.addr1 = '0; b.wdata0 = '0; b.wdata1 = '0;
    #3 chk("reset_outputs", all_outs(), '0);
    @(negedge ui_clk); @(negedge ui_clk);
    chk("reset_outputs_clocked", all_outs(), '0);
    sys_rst = 1;

    // uncalibrated: request must wait; grant follows calibration
    set_mem(0, 0, 1, '0);
    start_req(1'b0, 1'b1, 26'h0000020, 32'h20202020, '0, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge ui_clk);
      if (b.mem_en || b.mem_wea || b.busy) seen++;
    end
    chk("uncal_no_activity", seen, 0);
    b.calibrated = 1;
    @(negedge ui_clk);
    chk("cal_wdata_next_cycle", {b.mem_wea, b.mem_en}, 2'b10);
    wait_ack(1'b0, lat);
    chk("cal_latency", lat + 1, 3);
    @(posedge ui_clk); @(negedge ui_clk);

    for (int i = 0; i < 8; i++) begin
      set_mem(vecs[i].wd, vecs[i].cd, vecs[i].rl, vecs[i].rv);
      start_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rv, 1'b1);
      wait_ack(vecs[i].port, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      @(posedge ui_clk); @(negedge ui_clk);
      chk($sformatf("vec%0d_rdata0", i), b.rdata0, vecs[i].exp_rd0);
      chk($sformatf("vec%0d_rdata1", i), b.rdata1, vecs[i].exp_rd1);
    end

    // write with write_rdy held off for the first 4 wea cycles
    set_mem(4, 0, 1, '0);
    en_cyc = 0; wea_cyc = 0; encmd_cyc = 0;
    start_req(1'b0, 1'b1, 26'h0ABCDEF, 32'h5A5AF00F, '0, 1'b1);
    wait_ack(1'b0, lat);
    chk("wstall_latency", lat, 7);
    chk("wstall_wea_cycles", wea_cyc, 5);
    chk("wstall_en_cycles", en_cyc, 1);
    chk("wstall_cmd_is_write", encmd_cyc, 0);
    @(posedge ui_clk); @(negedge ui_clk);

    // calibration drops mid-read: transaction still completes
    set_mem(0, 1, 5, 32'h0BADF00D);
    start_req(1'b1, 1'b0, 26'h0000111, '0, 32'h0BADF00D, 1'b1);
    @(negedge ui_clk);
    b.calibrated = 0;
    wait_ack(1'b1, lat);
    chk("caldrop_latency", lat + 1, 8);
    b.calibrated = 1;
    @(posedge ui_clk); @(negedge ui_clk);

    // both ports contend: grants must alternate 0,1,0,1
    set_mem(0, 0, 2, 32'h55AA55AA);
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{1'b0, 1'b1, 26'h100 + 26'(k), 32'h0F000000 + k, 32'h0});
      sb_q.push_back('{1'b1, 1'b0, 26'h200 + 26'(k), 32'h0F000000 + k, 32'h55AA55AA});
    end
    fork
      port_loop(1'b0, 2);
      port_loop(1'b1, 2);
    join
    chk("rr_all_served", sb_q.size(), 0);

    // spurious read_arrived in IDLE
    @(posedge ui_clk); spur = 1;
    @(posedge ui_clk); spur = 0;
    @(negedge ui_clk);
    chk("spurious_err", b.err_spurious, 1'b1);
    chk("spurious_rdata0", b.rdata0, 32'hFFFFFFFF);
    chk("spurious_rdata1", b.rdata1, 32'h55AA55AA);

    // reset while waiting for read data
    set_mem(0, 0, 50, 32'h99999999);
    start_req(1'b0, 1'b0, 26'h0000333, '0, 32'h99999999, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ui_clk);
      if (b.busy && !b.mem_en && !b.mem_wea && !b.ack0 && !b.ack1) seen = 1;
    end
    chk("reached_rwait", seen, 1);
    #1 sys_rst = 0;
    #1 chk("rwait_reset_outputs", all_outs(), '0);
    b.req0 = 0;
    sb_q.delete();
    repeat (3) @(negedge ui_clk);
    chk("rwait_reset_held", all_outs(), '0);
    sys_rst = 1;
    seen = 0;
    repeat (10) begin
      @(negedge ui_clk);
      if (b.ack0 || b.ack1 || b.busy) seen++;
    end
    chk("no_ack_after_abort", seen, 0);

    set_mem(0, 0, 1, 32'h600DCAFE);
    start_req(1'b1, 1'b0, 26'h0000444, '0, 32'h600DCAFE, 1'b1);
    wait_ack(1'b1, lat);
    chk("resume_latency", lat, 3);
    @(posedge ui_clk); @(negedge ui_clk);
    chk("resume_rdata0", b.rdata0, 32'h0);
    chk("resume_rdata1", b.rdata1, 32'h600DCAFE);
    chk("en_wea_exclusive", illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
